// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch_ascii block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    SAT
  } sw_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         NUM_DIGITS  = 5;

  // BCD digit to its printable ASCII character.
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return ASCII_ZERO | {4'h0, d};
  endfunction

endpackage

// File: rtl/stopwatch_ascii_bcd_digit.sv
// One decade of the elapsed-time counter: mod-10 counter with ripple carry.
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  // Carry out is combinational so the whole cascade settles in one cycle.
  assign carry = inc && (digit == 4'd9);

  // Decade counter: clear wins over increment, 9 wraps to 0.
  // NOTE: sequential state uses non-blocking assignments so every flop in
  // the cascade samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ascii.sv
// Elapsed-time counter for the character LCD: prescaler, run/hold/saturate
// FSM, five-decade BCD cascade and ASCII presentation.
// Optional build macro: STOPWATCH_BLANK_EN (leading-zero blanking).
module stopwatch_ascii
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  output logic [7:0] time_vec1,
  output logic [7:0] time_vec2,
  output logic [7:0] time_vec3,
  output logic [7:0] time_vec4,
  output logic [7:0] time_vec5,
  output logic       start,
  output logic       running,
  output logic       overflow
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t             state;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic                  do_stop;
  logic                  do_start;
  logic                  count_tick;
  logic                  at_max;
  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] inc;
  logic [NUM_DIGITS-1:0] carry;
  logic                  unused_top_carry;
  logic [7:0]            ascii [NUM_DIGITS];

  // Command decode with clear > stop > start priority; stop and start are
  // only honoured in the states where they mean something.
  assign tick       = (state == RUN) && (presc == PRESC_LAST);
  assign do_stop    = btn_stop && !btn_clear && (state == RUN);
  assign do_start   = btn_start && !btn_clear && !btn_stop &&
                      ((state == IDLE) || (state == HOLD));
  assign count_tick = tick && !btn_clear && !btn_stop;

  // Saturation detect: all decades showing 9.
  always_comb begin
    at_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit[i] != 4'd9) at_max = 1'b0;
    end
  end

  // The cascade is held still on the saturating tick so the count pins at 99999.
  assign inc[0]           = count_tick && !at_max;
  assign unused_top_carry = carry[NUM_DIGITS-1];

  // Digit chain, index 0 = units.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_link
      assign inc[i] = carry[i-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (btn_clear),
      .inc   (inc[i]),
      .digit (digit[i]),
      .carry (carry[i])
    );
  end

  // Prescaler: free-runs 0..TICK_DIV-1 in RUN, freezes on stop, restarts on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (btn_clear || do_start) begin
      presc <= '0;
    end else if ((state == RUN) && !btn_stop) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start    <= 1'b0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else if (btn_clear) begin
      state    <= IDLE;
      start    <= 1'b0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else if (do_stop) begin
      state    <= HOLD;
      running  <= 1'b0;
    end else if (do_start) begin
      state    <= RUN;
      start    <= 1'b1;
      running  <= 1'b1;
    end else if (count_tick && at_max) begin
      state    <= SAT;
      running  <= 1'b0;
      overflow <= 1'b1;
    end
  end

`ifdef STOPWATCH_BLANK_EN
  // ASCII mapping with leading zeros shown as spaces; units always printed.
  // NOTE: every output gets a default before the loop so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin : blank_map
    logic leading;
    ascii   = '{default: ASCII_SPACE};
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (leading && (digit[i] == 4'd0) && (i != 0)) begin
        ascii[i] = ASCII_SPACE;
      end else begin
        ascii[i] = to_ascii(digit[i]);
        leading  = 1'b0;
      end
    end
  end
`else
  // Plain ASCII mapping of every digit.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ascii[i] = to_ascii(digit[i]);
    end
  end
`endif

  assign time_vec1 = ascii[4];
  assign time_vec2 = ascii[3];
  assign time_vec3 = ascii[2];
  assign time_vec4 = ascii[1];
  assign time_vec5 = ascii[0];

endmodule
